// File: rtl/rx_frame_sync_pkg.sv
// rtl/rx_frame_sync_pkg.sv - shared types, delimiter defaults and frame sizing for rx_frame_sync
// The CRC field width follows RX_FRAME_SYNC_CRC_EN.
package rx_frame_sync_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] START_CHAR = 8'hA5;
  localparam logic [7:0] END_CHAR   = 8'h5A;
  localparam logic [7:0] CRC8_POLY  = 8'h07;

`ifdef RX_FRAME_SYNC_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif

  function automatic int frame_bits(input int payload_bits, input int delim_bits);
    return 2 * delim_bits + payload_bits + CRC_BITS;
  endfunction

endpackage

// File: rtl/rx_crc8.sv
// rtl/rx_crc8.sv - combinational CRC-8 (init 0x00, MSB first) over a WIDTH-bit vector
module rx_crc8
  import rx_frame_sync_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [7:0]       crc_o
);

  always_comb begin
    logic [7:0] c;
    c = 8'h00;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ data_i[i]) ? CRC8_POLY : 8'h00);
    end
    crc_o = c;
  end

endmodule

// File: rtl/rx_frame_sync.sv
// rtl/rx_frame_sync.sv - serial frame hunter with HUNT/LOCKED flywheel and one-entry payload holding register
// Optional CRC-8 field and crc_err output under RX_FRAME_SYNC_CRC_EN.
module rx_frame_sync
  import rx_frame_sync_pkg::*;
#(
  parameter int                    PAYLOAD_BITS  = 48,
  parameter int                    DELIM_BITS    = 8,
  parameter logic [DELIM_BITS-1:0] START_PATTERN = DELIM_BITS'(START_CHAR),
  parameter logic [DELIM_BITS-1:0] END_PATTERN   = DELIM_BITS'(END_CHAR),
  parameter int                    MAX_MISSES    = 3,
  parameter int                    CNT_BITS      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  input  logic                    clear,
  output logic [PAYLOAD_BITS-1:0] pkt_data,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic                    locked,
  output logic                    overrun,
  output logic [CNT_BITS-1:0]     frame_count,
  output logic [CNT_BITS-1:0]     miss_count
`ifdef RX_FRAME_SYNC_CRC_EN
  ,
  output logic                    crc_err
`endif
);

  localparam int FB      = frame_bits(PAYLOAD_BITS, DELIM_BITS);
  localparam int CRC_W   = FB - 2 * DELIM_BITS - PAYLOAD_BITS;
  localparam int ALIGN_W = $clog2(FB);
  localparam logic [ALIGN_W-1:0]  ALIGN_FULL = ALIGN_W'(FB - 1);
  localparam logic [ALIGN_W-1:0]  ALIGN_NEXT = ALIGN_W'(FB - 2);
  localparam logic [ALIGN_W-1:0]  ALIGN_ONE  = 1;
  localparam logic [CNT_BITS-1:0] CNT_ONE    = 1;
  localparam logic [3:0]          MISS_LIMIT = 4'(MAX_MISSES);

  logic [FB-1:0]           sr_q, sr_d;
  state_e                  state_q, state_d;
  logic [ALIGN_W-1:0]      align_q, align_d;
  logic [3:0]              miss_q, miss_d;
  logic                    shifted_q, shifted_d;
  logic                    slot_q, slot_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic [CNT_BITS-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CNT_BITS-1:0]     miss_cnt_q, miss_cnt_d;
  logic                    crc_err_q, crc_err_d;

  logic                    delim_match, crc_ok, eval, good, bad_crc;
  logic [PAYLOAD_BITS-1:0] payload;

  assign delim_match = (sr_q[FB-1 -: DELIM_BITS] == START_PATTERN) &&
                       (sr_q[DELIM_BITS-1:0] == END_PATTERN);
  assign payload     = sr_q[DELIM_BITS+CRC_W +: PAYLOAD_BITS];

`ifdef RX_FRAME_SYNC_CRC_EN
  logic [7:0] crc_calc;
  rx_crc8 #(.WIDTH(PAYLOAD_BITS)) u_crc (
    .data_i (payload),
    .crc_o  (crc_calc)
  );
  assign crc_ok  = (crc_calc == sr_q[DELIM_BITS +: 8]);
  assign crc_err = crc_err_q;
`else
  assign crc_ok  = 1'b1;
`endif

  // HUNT looks at every new shift position; LOCKED only at the flywheel slot.
  assign eval    = (state_q == HUNT) ? shifted_q : slot_q;
  assign good    = eval && delim_match && crc_ok;
  assign bad_crc = eval && delim_match && !crc_ok;

  always_comb begin
    sr_d        = sr_q;
    state_d     = state_q;
    align_d     = align_q;
    miss_d      = miss_q;
    shifted_d   = bit_valid && !clear;
    slot_d      = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    crc_err_d   = bad_crc;

    if (bit_valid) sr_d = {sr_q[FB-2:0], bit_in};

    case (state_q)
      HUNT: begin
        if (bit_valid && align_q != '0) align_d = align_q - ALIGN_ONE;
        if (good) begin
          state_d = LOCKED;
          miss_d  = '0;
          // A bit arriving in the capture cycle already belongs to the next frame.
          align_d = bit_valid ? ALIGN_NEXT : ALIGN_FULL;
        end
      end
      LOCKED: begin
        if (bit_valid) begin
          if (align_q == '0) begin
            align_d = ALIGN_FULL;
            slot_d  = 1'b1;
          end else begin
            align_d = align_q - ALIGN_ONE;
          end
        end
        if (slot_q) begin
          if (good) begin
            miss_d = '0;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_ONE;
            if (miss_q + 4'd1 >= MISS_LIMIT) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (good) begin
      if (!valid_q || pkt_ready) begin
        data_d  = payload;
        valid_d = 1'b1;
        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_ONE;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pkt_ready) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      sr_d    = '0;
      state_d = HUNT;
      align_d = '0;
      miss_d  = '0;
      slot_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q        <= '0;
      state_q     <= HUNT;
      align_q     <= '0;
      miss_q      <= '0;
      shifted_q   <= 1'b0;
      slot_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      miss_cnt_q  <= '0;
      crc_err_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      state_q     <= state_d;
      align_q     <= align_d;
      miss_q      <= miss_d;
      shifted_q   <= shifted_d;
      slot_q      <= slot_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      crc_err_q   <= crc_err_d;
    end
  end

`ifndef RX_FRAME_SYNC_CRC_EN
  logic unused_crc_err;
  assign unused_crc_err = crc_err_q ^ bad_crc;
`endif

  assign pkt_data    = data_q;
  assign pkt_valid   = valid_q;
  assign locked      = (state_q == LOCKED);
  assign overrun     = overrun_q;
  assign frame_count = frame_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
// tb/tb_rx_frame_sync.sv - directed self-checking bench for rx_frame_sync (PAYLOAD_BITS=32, A5/5A)
// Exercises the CRC frame format when RX_FRAME_SYNC_CRC_EN is defined.
module tb_rx_frame_sync;

  logic        clk = 1'b0;
  logic        reset, bit_in, bit_valid, clear, pkt_ready;
  logic [31:0] pkt_data;
  logic        pkt_valid, locked, overrun;
  logic [15:0] frame_count, miss_count;
`ifdef RX_FRAME_SYNC_CRC_EN
  logic        crc_err;
`endif

  int errors = 0;
  int checks = 0;

  rx_frame_sync #(
    .PAYLOAD_BITS (32),
    .DELIM_BITS   (8),
    .START_PATTERN(8'hA5),
    .END_PATTERN  (8'h5A),
    .MAX_MISSES   (3),
    .CNT_BITS     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clear      (clear),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .locked     (locked),
    .overrun    (overrun),
    .frame_count(frame_count),
    .miss_count (miss_count)
`ifdef RX_FRAME_SYNC_CRC_EN
    ,
    .crc_err    (crc_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bit_in    = v[i];
      bit_valid = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  function automatic logic [63:0] frm(input logic [31:0] p, input logic [7:0] e);
    return {16'h0000, 8'hA5, p, e};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    bit_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; pkt_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, pkt_valid}, 32'd0);
    chk("rst_data", pkt_data, 32'd0);
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_frames", {16'b0, frame_count}, 32'd0);
    chk("rst_misses", {16'b0, miss_count}, 32'd0);
    reset = 1'b0;

`ifndef RX_FRAME_SYNC_CRC_EN
    // Noise, then a good frame with the consumer ready
    send_bits(64'b1101001101, 10);
    send_bits(frm(32'hDEADBEEF, 8'h5A), 48);
    idle(1);
    chk("lat_early_valid", {31'b0, pkt_valid}, 32'd0);
    idle(1);
    chk("first_valid", {31'b0, pkt_valid}, 32'd1);
    chk("first_data", pkt_data, 32'hDEADBEEF);
    chk("first_locked", {31'b0, locked}, 32'd1);
    chk("first_frames", {16'b0, frame_count}, 32'd1);
    idle(1);
    chk("first_consumed", {31'b0, pkt_valid}, 32'd0);

    // Back-to-back frames with the consumer stalled
    pulse_reset();
    pkt_ready = 1'b0;
    send_bits(frm(32'h11111111, 8'h5A), 48);
    send_bits(frm(32'h22222222, 8'h5A), 48);
    idle(1);
    chk("ovr_pre", {31'b0, overrun}, 32'd0);
    idle(1);
    chk("ovr_pulse", {31'b0, overrun}, 32'd1);
    chk("ovr_hold_data", pkt_data, 32'h11111111);
    chk("ovr_hold_valid", {31'b0, pkt_valid}, 32'd1);
    chk("ovr_frames", {16'b0, frame_count}, 32'd1);
    idle(1);
    chk("ovr_post", {31'b0, overrun}, 32'd0);
    pkt_ready = 1'b1;
    idle(1);
    chk("ovr_drain", {31'b0, pkt_valid}, 32'd0);

    // Three slots with corrupted END drop lock
    send_bits(frm(32'h33333333, 8'h5B), 48);
    idle(2);
    chk("miss1_count", {16'b0, miss_count}, 32'd1);
    chk("miss1_locked", {31'b0, locked}, 32'd1);
    send_bits(frm(32'h44444444, 8'h5B), 48);
    idle(2);
    chk("miss2_count", {16'b0, miss_count}, 32'd2);
    chk("miss2_locked", {31'b0, locked}, 32'd1);
    send_bits(frm(32'h55555555, 8'h5B), 48);
    idle(2);
    chk("miss3_count", {16'b0, miss_count}, 32'd3);
    chk("miss3_locked", {31'b0, locked}, 32'd0);
    send_bits(frm(32'hCAFEF00D, 8'h5A), 48);
    idle(2);
    chk("relock_valid", {31'b0, pkt_valid}, 32'd1);
    chk("relock_data", pkt_data, 32'hCAFEF00D);
    chk("relock_locked", {31'b0, locked}, 32'd1);
    chk("relock_frames", {16'b0, frame_count}, 32'd2);

    // Frame embedded 5 bits off the locked slot is ignored
    send_bits(64'd0, 5);
    send_bits(frm(32'h12345678, 8'h5A), 48);
    idle(2);
    chk("offset_valid", {31'b0, pkt_valid}, 32'd0);
    chk("offset_miss_a", {16'b0, miss_count}, 32'd4);
    send_bits(64'd0, 43);
    idle(2);
    chk("offset_miss_b", {16'b0, miss_count}, 32'd5);
    chk("offset_locked", {31'b0, locked}, 32'd1);
    chk("offset_frames", {16'b0, frame_count}, 32'd2);

    // Reset in the middle of a frame
    send_bits(frm(32'h0BADF00D, 8'h5A) >> 28, 20);
    pulse_reset();
    chk("midrst_data", pkt_data, 32'd0);
    chk("midrst_locked", {31'b0, locked}, 32'd0);
    chk("midrst_frames", {16'b0, frame_count}, 32'd0);
    chk("midrst_misses", {16'b0, miss_count}, 32'd0);
    send_bits(frm(32'h0BADF00D, 8'h5A), 48);
    idle(2);
    chk("postrst_valid", {31'b0, pkt_valid}, 32'd1);
    chk("postrst_data", pkt_data, 32'h0BADF00D);
    chk("postrst_frames", {16'b0, frame_count}, 32'd1);

    // clear forces HUNT but keeps the holding register and statistics
    @(negedge clk);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    chk("clear_locked", {31'b0, locked}, 32'd0);
    chk("clear_frames", {16'b0, frame_count}, 32'd1);
    chk("clear_data", pkt_data, 32'h0BADF00D);
`else
    // Payload 0x00000001 has CRC-8/0x07 = 0x07
    send_bits({8'hA5, 32'h00000001, 8'h08, 8'h5A}, 56);
    idle(1);
    chk("crcbad_pre", {31'b0, crc_err}, 32'd0);
    idle(1);
    chk("crcbad_pulse", {31'b0, crc_err}, 32'd1);
    chk("crcbad_valid", {31'b0, pkt_valid}, 32'd0);
    chk("crcbad_locked", {31'b0, locked}, 32'd0);
    idle(1);
    chk("crcbad_post", {31'b0, crc_err}, 32'd0);
    send_bits({8'hA5, 32'h00000001, 8'h07, 8'h5A}, 56);
    idle(2);
    chk("crcgood_valid", {31'b0, pkt_valid}, 32'd1);
    chk("crcgood_data", pkt_data, 32'h00000001);
    chk("crcgood_err", {31'b0, crc_err}, 32'd0);
    chk("crcgood_locked", {31'b0, locked}, 32'd1);
    chk("crcgood_frames", {16'b0, frame_count}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
